// File: rtl/ext_arbiter.sv
// Two-requester round-robin arbiter feeding a shared immediate extender.
// The single result register has one cycle of latency and a valid/ready output.
module ext_arbiter #(
  parameter int unsigned RR_INIT = 0,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [15:0]      req0_data,
  input  logic [1:0]       req0_op,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [15:0]      req1_data,
  input  logic [1:0]       req1_op,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_id,
  output logic             rsp_err,
  output logic [CNT_W-1:0] done_cnt
);

  localparam logic [1:0] OpZero    = 2'd0;
  localparam logic [1:0] OpSigned  = 2'd1;
  localparam logic [1:0] OpHighPos = 2'd2;

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic [31:0]      data_q, data_d;
  logic             id_q, id_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        can_accept;
  logic        both_valid;
  logic        grant1;
  logic        xfer;
  logic        consume;
  logic [15:0] sel_data;
  logic [1:0]  sel_op;
  logic [31:0] ext_data;
  logic        ext_err;

  assign can_accept = (state_q == StEmpty) || rsp_ready;
  assign both_valid = req0_valid && req1_valid;
  // Under contention the pointer decides; otherwise whoever is valid wins.
  assign grant1     = both_valid ? prio_q : req1_valid;
  assign xfer       = req0_ready || req1_ready;
  assign consume    = (state_q == StFull) && rsp_ready;

  assign sel_data = grant1 ? req1_data : req0_data;
  assign sel_op   = grant1 ? req1_op   : req0_op;

  always_comb begin
    ext_data = 32'd0;
    ext_err  = 1'b0;
    unique case (sel_op)
      OpZero:    ext_data = {16'd0, sel_data};
      OpSigned:  ext_data = {{16{sel_data[15]}}, sel_data};
      OpHighPos: ext_data = {sel_data, 16'd0};
      default:   ext_err  = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (xfer) begin
      state_d = StFull;
    end else if (consume) begin
      state_d = StEmpty;
    end
  end

  // Output logic.
  always_comb begin
    rsp_valid  = (state_q == StFull);
    req0_ready = can_accept && req0_valid && !grant1;
    req1_ready = can_accept && req1_valid && grant1;
    rsp_data   = data_q;
    rsp_id     = id_q;
    rsp_err    = err_q;
    done_cnt   = cnt_q;
  end

  always_comb begin
    data_d = data_q;
    id_d   = id_q;
    err_d  = err_q;
    prio_d = prio_q;
    cnt_d  = cnt_q;
    if (xfer) begin
      data_d = ext_data;
      id_d   = grant1;
      err_d  = ext_err;
      if (both_valid) begin
        prio_d = !grant1;
      end
    end
    if (consume) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= 32'd0;
      id_q   <= 1'b0;
      err_q  <= 1'b0;
      prio_q <= 1'(RR_INIT);
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      id_q   <= id_d;
      err_q  <= err_d;
      prio_q <= prio_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ext_arbiter.sv
// Directed bench for ext_arbiter: vector table for steady-state behaviour,
// hand sequences for backpressure, asynchronous reset and counter wrap.
module tb_ext_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_data, req1_data;
  logic [1:0]  req0_op, req1_op;
  logic        req0_ready, req1_ready;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_id, rsp_err;
  logic [7:0]  done_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ext_arbiter #(.RR_INIT(0), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_op    (req0_op),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_op    (req1_op),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_err    (rsp_err),
    .done_cnt   (done_cnt)
  );

  typedef struct {
    logic        v0;
    logic [15:0] d0;
    logic [1:0]  o0;
    logic        v1;
    logic [15:0] d1;
    logic [1:0]  o1;
    logic        rr;
    logic        e_rdy0;
    logic        e_rdy1;
    logic        e_valid;
    logic [31:0] e_data;
    logic        e_id;
    logic        e_err;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(logic v0, logic [15:0] d0, logic [1:0] o0, logic v1,
                              logic [15:0] d1, logic [1:0] o1, logic rr, logic r0, logic r1,
                              logic ev, logic [31:0] ed, logic ei, logic ee, logic [7:0] ec);
    vec_t v;
    v.v0 = v0; v.d0 = d0; v.o0 = o0; v.v1 = v1; v.d1 = d1; v.o1 = o1; v.rr = rr;
    v.e_rdy0 = r0; v.e_rdy1 = r1; v.e_valid = ev; v.e_data = ed; v.e_id = ei;
    v.e_err = ee; v.e_cnt = ec;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [15:0] d0, input logic [1:0] o0,
                       input logic v1, input logic [15:0] d1, input logic [1:0] o1,
                       input logic rr);
    req0_valid = v0; req0_data = d0; req0_op = o0;
    req1_valid = v1; req1_data = d1; req1_op = o1;
    rsp_ready  = rr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic ev, input logic [31:0] ed,
                           input logic ei, input logic ee, input logic [7:0] ec);
    check({tag, ".valid"}, 32'(rsp_valid), 32'(ev));
    check({tag, ".data"},  rsp_data, ed);
    check({tag, ".id"},    32'(rsp_id), 32'(ei));
    check({tag, ".err"},   32'(rsp_err), 32'(ee));
    check({tag, ".cnt"},   32'(done_cnt), 32'(ec));
  endtask

  task automatic check_rdy(input string tag, input logic r0, input logic r1);
    check({tag, ".ready0"}, 32'(req0_ready), 32'(r0));
    check({tag, ".ready1"}, 32'(req1_ready), 32'(r1));
  endtask

  initial begin
    // Contention expectations assume the pointer starts at 0 after reset.
    vecs[0]  = mk(1, 16'h8001, 2'd1, 0, 16'h0000, 2'd0, 1, 1, 0, 1, 32'hFFFF8001, 0, 0, 8'd0);
    vecs[1]  = mk(0, 16'h0000, 2'd0, 0, 16'h0000, 2'd0, 1, 0, 0, 0, 32'hFFFF8001, 0, 0, 8'd1);
    vecs[2]  = mk(0, 16'h0000, 2'd0, 1, 16'h1234, 2'd0, 1, 0, 1, 1, 32'h00001234, 1, 0, 8'd1);
    vecs[3]  = mk(1, 16'h1234, 2'd2, 0, 16'h0000, 2'd0, 1, 1, 0, 1, 32'h12340000, 0, 0, 8'd2);
    vecs[4]  = mk(0, 16'h0000, 2'd0, 1, 16'h1234, 2'd3, 1, 0, 1, 1, 32'h00000000, 1, 1, 8'd3);
    vecs[5]  = mk(1, 16'h00FF, 2'd1, 0, 16'h0000, 2'd0, 0, 0, 0, 1, 32'h00000000, 1, 1, 8'd3);
    vecs[6]  = mk(1, 16'h00FF, 2'd1, 0, 16'h0000, 2'd0, 1, 1, 0, 1, 32'h000000FF, 0, 0, 8'd4);
    vecs[7]  = mk(0, 16'h0000, 2'd0, 0, 16'h0000, 2'd0, 1, 0, 0, 0, 32'h000000FF, 0, 0, 8'd5);
    vecs[8]  = mk(1, 16'hAAAA, 2'd0, 1, 16'h5555, 2'd0, 1, 1, 0, 1, 32'h0000AAAA, 0, 0, 8'd5);
    vecs[9]  = mk(1, 16'hAAAA, 2'd0, 1, 16'h5555, 2'd0, 1, 0, 1, 1, 32'h00005555, 1, 0, 8'd6);
    vecs[10] = mk(1, 16'hAAAA, 2'd0, 1, 16'h5555, 2'd0, 1, 1, 0, 1, 32'h0000AAAA, 0, 0, 8'd7);
    vecs[11] = mk(1, 16'hAAAA, 2'd0, 1, 16'h5555, 2'd0, 1, 0, 1, 1, 32'h00005555, 1, 0, 8'd8);
    vecs[12] = mk(0, 16'h0000, 2'd0, 0, 16'h0000, 2'd0, 1, 0, 0, 0, 32'h00005555, 1, 0, 8'd9);

    rst_n = 1'b0;
    drive(0, 16'h0, 2'd0, 0, 16'h0, 2'd0, 0);
    #7;
    check_out("reset", 0, 32'h0, 0, 0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].v0, vecs[i].d0, vecs[i].o0, vecs[i].v1, vecs[i].d1, vecs[i].o1, vecs[i].rr);
      #1;
      check_rdy($sformatf("vec%0d", i), vecs[i].e_rdy0, vecs[i].e_rdy1);
      step();
      check_out($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_data, vecs[i].e_id,
                vecs[i].e_err, vecs[i].e_cnt);
    end

    // Backpressure: fill, then stall three cycles with both requesters waiting.
    drive(1, 16'h1111, 2'd0, 0, 16'h0, 2'd0, 0);
    #1;
    check_rdy("bp_fill", 1, 0);
    step();
    check_out("bp_fill", 1, 32'h00001111, 0, 0, 8'd9);
    drive(1, 16'h2222, 2'd0, 1, 16'h3333, 2'd0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_rdy($sformatf("bp_stall%0d", i), 0, 0);
      step();
      check_out($sformatf("bp_stall%0d", i), 1, 32'h00001111, 0, 0, 8'd9);
    end
    rsp_ready = 1'b1;
    #1;
    check_rdy("bp_release", 1, 0);
    step();
    check_out("bp_release", 1, 32'h00002222, 0, 0, 8'd10);
    drive(0, 16'h0, 2'd0, 1, 16'h3333, 2'd0, 1);
    #1;
    check_rdy("bp_next", 0, 1);
    step();
    check_out("bp_next", 1, 32'h00003333, 1, 0, 8'd11);

    // Reset mid-cycle while FULL; pointer is 1 at this point.
    drive(0, 16'h0, 2'd0, 0, 16'h0, 2'd0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 0, 32'h0, 0, 0, 8'd0);
    drive(1, 16'h4444, 2'd0, 1, 16'h5555, 2'd0, 1);
    step();
    check_out("rst_hold", 0, 32'h0, 0, 0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_rdy("post_rst", 1, 0);
    step();
    check_out("post_rst", 1, 32'h00004444, 0, 0, 8'd0);

    // Counter wrap: 256 consumed results bring done_cnt back to 0.
    drive(0, 16'h0, 2'd0, 0, 16'h0, 2'd0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("wrap_rst.cnt", 32'(done_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 16'h0001, 2'd0, 0, 16'h0, 2'd0, 1);
    for (int i = 0; i < 256; i++) step();
    check("wrap_255.cnt", 32'(done_cnt), 32'd255);
    req0_valid = 1'b0;
    step();
    check("wrap_0.cnt", 32'(done_cnt), 32'd0);
    check("wrap_0.valid", 32'(rsp_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ext_arbiter.md
EXT_ARBITER -- requirements
Module: ext_arbiter

Interface
REQ-001 SHALL have parameter RR_INIT, default 0, meaning the requester that holds priority after reset (0 or 1).
REQ-002 SHALL have parameter CNT_W, default 8, meaning the width of the completed-operation counter.
REQ-003 SHALL have port clk  input  1  system clock; all state changes occur on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req0_valid  input  1  requester 0 (ID-stage immediate) has an operation pending.
REQ-006 SHALL have port req0_data  input  16  requester 0 immediate.
REQ-007 SHALL have port req0_op  input  2  requester 0 extension code: 0 = EXT_ZERO, 1 = EXT_SIGNED, 2 = EXT_HIGHPOS, 3 = illegal.
REQ-008 SHALL have port req0_ready  output  1  requester 0 operation accepted in this cycle.
REQ-009 SHALL have ports req1_valid, req1_data, req1_op and req1_ready, identical to REQ-005 to REQ-008, for requester 1 (MEM-stage load halfword).
REQ-010 SHALL have port rsp_valid  output  1  rsp_data, rsp_id and rsp_err hold a result.
REQ-011 SHALL have port rsp_ready  input  1  consumer takes the result.
REQ-012 SHALL have port rsp_data  output  32  extended value.
REQ-013 SHALL have port rsp_id  output  1  requester that owns rsp_data.
REQ-014 SHALL have port rsp_err  output  1  the operation used illegal code 3.
REQ-015 SHALL have port done_cnt  output  CNT_W  number of results consumed, wrapping at the maximum.

Function
REQ-016 SHALL have two FSM states: EMPTY (no result held) and FULL (result held). rsp_valid SHALL be 1 exactly in FULL.
REQ-017 SHALL define can_accept = (state == EMPTY) or (rsp_ready == 1).
REQ-018 SHALL define arbitration: with one valid requester, grant it; with both valid, grant the requester named by the priority pointer; with none valid, grant none.
REQ-019 SHALL drive reqN_ready combinationally, high only when can_accept is 1, reqN_valid is 1 and N is granted; at most one ready per cycle.
REQ-020 SHALL make the transfer on the edge where reqN_valid and reqN_ready are both 1, loading rsp_data, rsp_id = N and rsp_err, then entering FULL.
REQ-021 SHALL compute rsp_data for code 0 as {16'd0, data}, code 1 as {16{data[15]}, data}, and code 2 as {data, 16'd0}.
REQ-022 SHALL, for code 3, set rsp_data to 32'd0 and rsp_err to 1; otherwise rsp_err SHALL be 0.
REQ-023 SHALL keep a latency of one cycle, so a transfer at edge N gives rsp_valid = 1 after edge N.
REQ-024 SHALL, with rsp_ready held high, sustain one result per cycle (consume and refill on the same edge).
REQ-025 SHALL, in FULL with rsp_ready = 0, hold rsp_data, rsp_id and rsp_err stable, and all readys SHALL be 0.
REQ-026 SHALL, in FULL with rsp_ready = 1 and no transfer, move to EMPTY; rsp_data SHALL keep its last value.
REQ-027 SHALL toggle the priority pointer to the other requester only on a transfer made while both requesters were valid.
REQ-028 SHALL increment done_cnt on each edge where rsp_valid and rsp_ready are both 1, wrapping from 2^CNT_W-1 to 0.
REQ-029 SHALL not drop or duplicate operations; a requester holds valid, data and op until it sees ready.

Reset
REQ-030 SHALL, while rst_n = 0, immediately force: state EMPTY, rsp_valid 0, rsp_data 0, rsp_id 0, rsp_err 0, done_cnt 0, priority pointer RR_INIT.
REQ-031 SHALL discard any held result when reset asserts while FULL; no transfer occurs while rst_n = 0.
REQ-032 SHALL allow a transfer on the first rising edge after rst_n deasserts.

Verification
REQ-033 SHALL test single request: req0 valid, data 16'h8001, op 1, rsp_ready 1 -> next cycle rsp_data 32'hFFFF8001, rsp_id 0, rsp_err 0, and done_cnt becomes 1.
REQ-034 SHALL test all codes on data 16'h1234: op 0 -> 32'h00001234, op 2 -> 32'h12340000, op 3 -> 32'h0 with rsp_err 1.
REQ-035 SHALL test contention: both requesters valid for 4 cycles with RR_INIT 0 and rsp_ready 1 -> rsp_id sequence 0, 1, 0, 1, one result per cycle.
REQ-036 SHALL test backpressure: rsp_ready 0 for 3 cycles while FULL -> both readys 0, outputs stable, done_cnt unchanged; rsp_ready 1 -> consumed, then the next grant.
REQ-037 SHALL test reset while FULL: rst_n low in mid-cycle -> rsp_valid 0 at once without waiting for clk, done_cnt 0, and the first grant after release goes to RR_INIT.
REQ-038 SHALL test wrap: 256 consumed results with CNT_W 8 -> done_cnt returns to 0.
